// File: rtl/alu_rsv_station.sv
// ============================================================================
//  Module   : alu_rsv_station
//  Purpose  : Integer-ALU reservation station. Buffers dispatched ops whose
//             operands may still be in flight, snoops the CDB by tag, and
//             issues the lowest-index fully-ready op once per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ALU_OPCODE_WIDTH
`define ALU_OPCODE_WIDTH 4
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module alu_rsv_station #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 4,
   parameter int DATA_W = `REG_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         disp_valid,
   output logic                         disp_ready,
   input  logic [`ALU_OPCODE_WIDTH-1:0] disp_opcode,
   input  logic [TAG_W-1:0]             disp_dst_tag,
   input  logic                         disp_src1_rdy,
   input  logic [TAG_W-1:0]             disp_src1_tag,
   input  logic [DATA_W-1:0]            disp_src1_val,
   input  logic                         disp_src2_rdy,
   input  logic [TAG_W-1:0]             disp_src2_tag,
   input  logic [DATA_W-1:0]            disp_src2_val,
   input  logic                         cdb_valid,
   input  logic [TAG_W-1:0]             cdb_tag,
   input  logic [DATA_W-1:0]            cdb_data,
   input  logic                         alu_busy,
   output logic                         issue_valid,
   output logic [`ALU_OPCODE_WIDTH-1:0] issue_opcode,
   output logic [DATA_W-1:0]            issue_src1,
   output logic [DATA_W-1:0]            issue_src2,
   output logic [TAG_W-1:0]             issue_tag,
   output logic [$clog2(DEPTH):0]       occupancy
);

   localparam int IW  = $clog2(DEPTH);
   localparam int OPW = `ALU_OPCODE_WIDTH;
   localparam logic [IW:0] C_DEPTH = (IW+1)'(DEPTH);

   // Per-entry storage; an entry is Free when !valid, Ready when both rdy set
   logic [DEPTH-1:0]  r_valid;
   logic [OPW-1:0]    r_opcode  [DEPTH];
   logic [TAG_W-1:0]  r_dst_tag [DEPTH];
   logic [DEPTH-1:0]  r_s1_rdy;
   logic [TAG_W-1:0]  r_s1_tag  [DEPTH];
   logic [DATA_W-1:0] r_s1_val  [DEPTH];
   logic [DEPTH-1:0]  r_s2_rdy;
   logic [TAG_W-1:0]  r_s2_tag  [DEPTH];
   logic [DATA_W-1:0] r_s2_val  [DEPTH];
   logic [IW:0]       r_occ;

   logic [IW-1:0]     w_free_idx;
   logic [IW-1:0]     w_sel_idx;
   logic              w_sel_found;
   logic              w_issue;
   logic              w_disp_acc;
   logic              w_d_s1_rdy;
   logic              w_d_s2_rdy;
   logic [DATA_W-1:0] w_d_s1_val;
   logic [DATA_W-1:0] w_d_s2_val;

   // Free space is judged on registered occupancy only, so an issue this cycle
   // never makes room for a dispatch this cycle.
   assign disp_ready = (r_occ != C_DEPTH);
   assign w_disp_acc = disp_valid & disp_ready;
   assign w_issue    = w_sel_found & ~alu_busy;
   assign occupancy  = r_occ;

   // Dispatch bypass: a pending source whose producer is on the CDB right now
   // is captured as ready, otherwise it would miss the broadcast forever.
   assign w_d_s1_rdy = disp_src1_rdy | (cdb_valid & (cdb_tag == disp_src1_tag));
   assign w_d_s2_rdy = disp_src2_rdy | (cdb_valid & (cdb_tag == disp_src2_tag));
   assign w_d_s1_val = disp_src1_rdy ? disp_src1_val : cdb_data;
   assign w_d_s2_val = disp_src2_rdy ? disp_src2_val : cdb_data;

   // Lowest-index free slot and lowest-index ready slot (scan high->low so the lowest wins)
   always_comb begin
      w_free_idx  = '0;
      w_sel_idx   = '0;
      w_sel_found = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_valid[i]) begin
            w_free_idx = IW'(i);
         end
         if (r_valid[i] && r_s1_rdy[i] && r_s2_rdy[i]) begin
            w_sel_idx   = IW'(i);
            w_sel_found = 1'b1;
         end
      end
   end

   // Entry state, wakeup, issue registers and occupancy; flush acts like reset
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_valid      <= '0;
         r_occ        <= '0;
         issue_valid  <= 1'b0;
         issue_opcode <= '0;
         issue_src1   <= '0;
         issue_src2   <= '0;
         issue_tag    <= '0;
      end else begin
         // Wakeup uses the pre-edge ready bits, so a woken entry selects next cycle
         for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !r_s1_rdy[i] && cdb_valid && (cdb_tag == r_s1_tag[i])) begin
               r_s1_rdy[i] <= 1'b1;
               r_s1_val[i] <= cdb_data;
            end
            if (r_valid[i] && !r_s2_rdy[i] && cdb_valid && (cdb_tag == r_s2_tag[i])) begin
               r_s2_rdy[i] <= 1'b1;
               r_s2_val[i] <= cdb_data;
            end
         end

         if (w_issue) begin
            r_valid[w_sel_idx] <= 1'b0;
            issue_valid        <= 1'b1;
            issue_opcode       <= r_opcode[w_sel_idx];
            issue_src1         <= r_s1_val[w_sel_idx];
            issue_src2         <= r_s2_val[w_sel_idx];
            issue_tag          <= r_dst_tag[w_sel_idx];
         end else begin
            issue_valid <= 1'b0;
         end

         // The free slot is never the issuing slot, so these writes cannot collide
         if (w_disp_acc) begin
            r_valid[w_free_idx]   <= 1'b1;
            r_opcode[w_free_idx]  <= disp_opcode;
            r_dst_tag[w_free_idx] <= disp_dst_tag;
            r_s1_rdy[w_free_idx]  <= w_d_s1_rdy;
            r_s1_tag[w_free_idx]  <= disp_src1_tag;
            r_s1_val[w_free_idx]  <= w_d_s1_val;
            r_s2_rdy[w_free_idx]  <= w_d_s2_rdy;
            r_s2_tag[w_free_idx]  <= disp_src2_tag;
            r_s2_val[w_free_idx]  <= w_d_s2_val;
         end

         r_occ <= r_occ + (IW+1)'(w_disp_acc) - (IW+1)'(w_issue);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_rsv_station.sv
// ============================================================================
//  Module   : tb_alu_rsv_station
//  Purpose  : Self-checking bench for alu_rsv_station; expected issues are
//             queued as stimulus is driven and compared as the DUT issues.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_rsv_station;

   localparam int DEPTH  = 4;
   localparam int TAG_W  = 4;
   localparam int DATA_W = 32;
   localparam int OPW    = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              disp_valid;
   logic              disp_ready;
   logic [OPW-1:0]    disp_opcode;
   logic [TAG_W-1:0]  disp_dst_tag;
   logic              disp_src1_rdy;
   logic [TAG_W-1:0]  disp_src1_tag;
   logic [DATA_W-1:0] disp_src1_val;
   logic              disp_src2_rdy;
   logic [TAG_W-1:0]  disp_src2_tag;
   logic [DATA_W-1:0] disp_src2_val;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic              alu_busy;
   logic              issue_valid;
   logic [OPW-1:0]    issue_opcode;
   logic [DATA_W-1:0] issue_src1;
   logic [DATA_W-1:0] issue_src2;
   logic [TAG_W-1:0]  issue_tag;
   logic [2:0]        occupancy;

   typedef struct packed {
      logic [OPW-1:0]    op;
      logic [DATA_W-1:0] s1;
      logic [DATA_W-1:0] s2;
      logic [TAG_W-1:0]  tag;
   } exp_t;

   exp_t exp_q [$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc_cnt  = 0;

   alu_rsv_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_opcode(disp_opcode), .disp_dst_tag(disp_dst_tag),
      .disp_src1_rdy(disp_src1_rdy), .disp_src1_tag(disp_src1_tag), .disp_src1_val(disp_src1_val),
      .disp_src2_rdy(disp_src2_rdy), .disp_src2_tag(disp_src2_tag), .disp_src2_val(disp_src2_val),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .alu_busy(alu_busy),
      .issue_valid(issue_valid), .issue_opcode(issue_opcode),
      .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_tag(issue_tag),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   // Single comparison point for every check in the bench
   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, obs, exp, cyc_cnt);
      end
   endtask

   // Scoreboard: every issue must match the oldest outstanding expectation
   always @(negedge clk) begin
      cyc_cnt++;
      if (issue_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_issue", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("issue_opcode", 64'(issue_opcode), 64'(e.op));
            check("issue_src1",   64'(issue_src1),   64'(e.s1));
            check("issue_src2",   64'(issue_src2),   64'(e.s2));
            check("issue_tag",    64'(issue_tag),    64'(e.tag));
         end
      end
      if (cyc_cnt > 5000) begin
         $display("FAIL watchdog: got %0d cycles expected < 5000", cyc_cnt);
         $fatal(1, "watchdog expired");
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle();
      disp_valid = 1'b0;
      cdb_valid  = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic disp(input logic [OPW-1:0] op, input logic [TAG_W-1:0] dst,
                       input logic r1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1,
                       input logic r2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v2);
      disp_valid    = 1'b1;
      disp_opcode   = op;
      disp_dst_tag  = dst;
      disp_src1_rdy = r1;
      disp_src1_tag = t1;
      disp_src1_val = v1;
      disp_src2_rdy = r2;
      disp_src2_tag = t2;
      disp_src2_val = v2;
   endtask

   task automatic bcast(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
      cdb_valid = 1'b1;
      cdb_tag   = t;
      cdb_data  = d;
   endtask

   task automatic push(input logic [OPW-1:0] op, input logic [DATA_W-1:0] s1,
                       input logic [DATA_W-1:0] s2, input logic [TAG_W-1:0] tag);
      exp_t e;
      e.op = op; e.s1 = s1; e.s2 = s2; e.tag = tag;
      exp_q.push_back(e);
   endtask

   // Bounded wait for all queued issues to appear and the station to empty
   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || occupancy != 0) && n < 20) begin
         cyc();
         n++;
      end
      check(name, 64'(exp_q.size()) + 64'(occupancy), 64'd0);
   endtask

   initial begin
      rst = 1'b1; alu_busy = 1'b0;
      idle();
      disp(4'h0, 4'h0, 1'b0, 4'h0, '0, 1'b0, 4'h0, '0);
      disp_valid = 1'b0;
      bcast(4'h0, '0);
      cdb_valid = 1'b0;
      cyc(); cyc();
      rst = 1'b0;

      // Reset state
      check("rst_occupancy",   64'(occupancy),   64'd0);
      check("rst_issue_valid", 64'(issue_valid), 64'd0);
      check("rst_disp_ready",  64'(disp_ready),  64'd1);
      check("rst_issue_src1",  64'(issue_src1),  64'd0);

      // 1: ready ADD issues the cycle after it lands in the station
      disp(4'h0, 4'h1, 1'b1, 4'h0, 32'd5, 1'b1, 4'h0, 32'd7);
      push(4'h0, 32'd5, 32'd7, 4'h1);
      cyc(); idle();
      check("t1_occ_after_disp", 64'(occupancy),   64'd1);
      check("t1_no_issue_yet",   64'(issue_valid), 64'd0);
      cyc();
      check("t1_issue_valid",    64'(issue_valid), 64'd1);
      check("t1_occ_after_iss",  64'(occupancy),   64'd0);
      cyc();
      check("t1_one_cycle_pulse", 64'(issue_valid), 64'd0);

      // 2: src1 waits on tag 3; CDB at t -> issue at t+2
      disp(4'h1, 4'h2, 1'b0, 4'h3, 32'hDEAD, 1'b1, 4'h0, 32'h20);
      push(4'h1, 32'h10, 32'h20, 4'h2);
      cyc(); idle();
      cyc();
      check("t2_waiting", 64'(issue_valid), 64'd0);
      bcast(4'h3, 32'h10);
      cyc(); idle();
      check("t2_t_plus_1", 64'(issue_valid), 64'd0);
      cyc();
      check("t2_t_plus_2", 64'(issue_valid), 64'd1);
      cyc();

      // 3: fill with pending ops, 5th dispatch is dropped
      for (int i = 0; i < DEPTH; i++) begin
         disp(4'h2, 4'(4 + i), 1'b0, 4'h8, '0, 1'b1, 4'h0, 32'(100 + i));
         push(4'h2, 32'h88, 32'(100 + i), 4'(4 + i));
         cyc();
      end
      idle();
      check("t3_full_ready", 64'(disp_ready), 64'd0);
      check("t3_full_occ",   64'(occupancy),  64'd4);
      disp(4'h7, 4'hF, 1'b1, 4'h0, 32'h1, 1'b1, 4'h0, 32'h2);
      cyc(); idle();
      check("t3_drop_occ",   64'(occupancy),  64'd4);
      cyc();
      check("t3_drop_noiss", 64'(issue_valid), 64'd0);
      bcast(4'h8, 32'h88);
      cyc(); idle();
      drain("t3_drain");

      // 4: entries 0 and 2 ready, 1 pending, ALU busy holds issue
      alu_busy = 1'b1;
      disp(4'h2, 4'h1, 1'b1, 4'h0, 32'h11, 1'b1, 4'h0, 32'h22);
      push(4'h2, 32'h11, 32'h22, 4'h1);
      cyc();
      disp(4'h5, 4'h2, 1'b0, 4'h5, '0, 1'b1, 4'h0, 32'h66);
      cyc();
      disp(4'h3, 4'h3, 1'b1, 4'h0, 32'h33, 1'b1, 4'h0, 32'h44);
      push(4'h3, 32'h33, 32'h44, 4'h3);
      cyc(); idle();
      cyc();
      check("t4_busy_1", 64'(issue_valid), 64'd0);
      cyc();
      check("t4_busy_2", 64'(issue_valid), 64'd0);
      check("t4_busy_occ", 64'(occupancy), 64'd3);
      alu_busy = 1'b0;
      cyc();
      check("t4_issue_e0", 64'(issue_valid), 64'd1);
      cyc();
      check("t4_issue_e2", 64'(issue_valid), 64'd1);
      cyc();
      check("t4_e1_waits", 64'(issue_valid), 64'd0);
      bcast(4'h5, 32'h55);
      push(4'h5, 32'h55, 32'h66, 4'h2);
      cyc(); idle();
      drain("t4_drain");

      // 5: dispatch bypass of same-cycle CDB on src2
      disp(4'h4, 4'h6, 1'b1, 4'h0, 32'h1, 1'b0, 4'h9, '0);
      bcast(4'h9, 32'hAB);
      push(4'h4, 32'h1, 32'hAB, 4'h6);
      cyc(); idle();
      check("t5_occ", 64'(occupancy), 64'd1);
      cyc();
      check("t5_issue", 64'(issue_valid), 64'd1);
      cyc();

      // 6a: flush beats a same-cycle dispatch
      for (int i = 0; i < 3; i++) begin
         disp(4'h6, 4'(8 + i), 1'b0, 4'hC, '0, 1'b1, 4'h0, 32'h5);
         cyc();
      end
      idle();
      disp(4'h6, 4'hE, 1'b1, 4'h0, 32'h9, 1'b1, 4'h0, 32'h9);
      flush = 1'b1;
      cyc(); idle();
      check("t6_flush_occ",   64'(occupancy),   64'd0);
      check("t6_flush_iv",    64'(issue_valid), 64'd0);
      check("t6_flush_src1",  64'(issue_src1),  64'd0);
      check("t6_flush_ready", 64'(disp_ready),  64'd1);
      bcast(4'hC, 32'hCC);
      cyc(); idle();
      cyc(); cyc();
      check("t6_flush_stale", 64'(issue_valid), 64'd0);

      // 6b: reset mid-fill clears entries and issue data
      disp(4'h1, 4'h7, 1'b1, 4'h0, 32'h77, 1'b1, 4'h0, 32'h78);
      push(4'h1, 32'h77, 32'h78, 4'h7);
      cyc(); idle();
      cyc(); cyc();
      for (int i = 0; i < 2; i++) begin
         disp(4'h6, 4'(1 + i), 1'b0, 4'hD, '0, 1'b1, 4'h0, 32'h3);
         cyc();
      end
      rst = 1'b1;
      cyc(); idle();
      rst = 1'b0;
      check("t6_rst_occ",  64'(occupancy),   64'd0);
      check("t6_rst_iv",   64'(issue_valid), 64'd0);
      check("t6_rst_src1", 64'(issue_src1),  64'd0);
      bcast(4'hD, 32'hDD);
      cyc(); idle();
      cyc(); cyc();
      check("t6_rst_stale", 64'(issue_valid), 64'd0);
      check("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
